// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-timing helpers
// used by the receive engine and the future transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  function automatic int sample_time(input int clock_freq, input int baud_rate);
    return symbol_edge_time(clock_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level input; resets to 1 so an
// idle-high line does not look active while reset releases.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive engine, 8N1 LSB first, with valid/ready holding register.
// Define UART_RX_PARITY_EN to expect an even-parity bit after the data bits.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int ClockFreq = 50_000_000,
  parameter int BaudRate  = 115_200
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       SIn,
  output logic [7:0] DataOut,
  output logic       DataOutValid,
  input  logic       DataOutReady,
  output logic       FramingError,
  output logic       Overrun,
  output logic       ParityError
);

  localparam int SymbolEdgeTime = symbol_edge_time(ClockFreq, BaudRate);
  localparam int SampleTime     = sample_time(ClockFreq, BaudRate);
  localparam int CounterWidth   = $clog2(SymbolEdgeTime);

  localparam logic [CounterWidth-1:0] EdgeLast   = CounterWidth'(SymbolEdgeTime - 1);
  localparam logic [CounterWidth-1:0] SampleLast = CounterWidth'(SampleTime - 1);

  logic                    rx;
  rx_state_t               state;
  logic [CounterWidth-1:0] cnt;
  logic [2:0]              bit_idx;
  logic [7:0]              shift;
  logic                    cnt_wrap;
  logic                    stop_sample;
  logic                    parity_ok;
  logic                    byte_done;

  sync_2ff u_sync (
    .clk   (Clock),
    .rst_n (Reset),
    .d     (SIn),
    .q     (rx)
  );

  assign cnt_wrap    = (cnt == EdgeLast);
  assign stop_sample = (state == STOP) && cnt_wrap;

`ifdef UART_RX_PARITY_EN
  logic parity_bit;
  assign parity_ok = (parity_bit == ^shift);
`else
  assign parity_ok   = 1'b1;
  assign ParityError = 1'b0;
`endif

  // Framing error wins over parity: a low stop bit never reports parity.
  assign byte_done = stop_sample && rx && parity_ok;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      DataOut      <= 8'h00;
      DataOutValid <= 1'b0;
      FramingError <= 1'b0;
      Overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit   <= 1'b0;
      ParityError  <= 1'b0;
`endif
    end else begin
      FramingError <= 1'b0;
      Overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      ParityError  <= 1'b0;
      if (stop_sample && rx && !parity_ok) ParityError <= 1'b1;
`endif
      if (DataOutValid && DataOutReady) DataOutValid <= 1'b0;

      // A byte finishing in the same cycle the consumer takes the old one reloads.
      if (byte_done) begin
        if (!DataOutValid || DataOutReady) begin
          DataOut      <= shift;
          DataOutValid <= 1'b1;
        end else begin
          Overrun <= 1'b1;
        end
      end
      if (stop_sample && !rx) FramingError <= 1'b1;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx) state <= START;
        end
        START: begin
          if (cnt == SampleLast) begin
            cnt <= '0;
            if (!rx) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt_wrap) begin
            cnt     <= '0;
            shift   <= {rx, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bit_idx == 3'd7) state <= PARITY;
`else
            if (bit_idx == 3'd7) state <= STOP;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_wrap) begin
            cnt        <= '0;
            parity_bit <= rx;
            state      <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          // Back to IDLE at mid stop bit so the next start edge is not missed.
          if (cnt_wrap) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at default timing; received bytes are
// checked against a queue of expected bytes filled as frames are sent.
module tb_uart_receiver;

  localparam int Bit = 434;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       SIn = 1'b1;
  logic       DataOutReady = 1'b0;
  logic [7:0] DataOut;
  logic       DataOutValid;
  logic       FramingError;
  logic       Overrun;
  logic       ParityError;

  int total = 0;
  int bad = 0;
  int framing_cnt = 0;
  int overrun_cnt = 0;
  int parity_cnt = 0;
  int valid_cycles = 0;
  int accepted = 0;
  int vc_snap = 0;
  logic [7:0] exp_q[$];

  uart_receiver dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .SIn          (SIn),
    .DataOut      (DataOut),
    .DataOutValid (DataOutValid),
    .DataOutReady (DataOutReady),
    .FramingError (FramingError),
    .Overrun      (Overrun),
    .ParityError  (ParityError)
  );

  always #10 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val, input logic par_bad);
    SIn = 1'b0;
    step(Bit);
    for (int i = 0; i < 8; i++) begin
      SIn = b[i];
      step(Bit);
    end
`ifdef UART_RX_PARITY_EN
    SIn = (^b) ^ par_bad;
    step(Bit);
`endif
    SIn = stop_val;
    step(Bit);
    SIn = 1'b1;
  endtask

  always @(negedge Clock) begin
    logic [7:0] e;
    if (Reset) begin
      if (FramingError) framing_cnt++;
      if (Overrun) overrun_cnt++;
      if (ParityError) parity_cnt++;
      if (DataOutValid) valid_cycles++;
      if (DataOutValid && DataOutReady) begin
        accepted++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL unexpected_byte observed=%0h required=none", DataOut);
        end else begin
          e = exp_q.pop_front();
          check("byte", {24'h0, DataOut}, {24'h0, e});
          $display("rx byte observed=%02h expected=%02h", DataOut, e);
        end
      end
    end
  end

  initial begin
    step(5);
    check("rst_data", {24'h0, DataOut}, 32'h00);
    check("rst_valid", {31'h0, DataOutValid}, 32'h0);
    check("rst_ferr", {31'h0, FramingError}, 32'h0);
    check("rst_ovr", {31'h0, Overrun}, 32'h0);
    Reset = 1'b1;
    step(20);
    check("idle_valid", {31'h0, DataOutValid}, 32'h0);

    // Single frame, consumer always ready
    DataOutReady = 1'b1;
    exp_q.push_back(8'h7a);
    send_frame(8'h7a, 1'b1, 1'b0);
    step(50);
    check("f1_accepted", accepted, 1);
    check("f1_valid_cycles", valid_cycles, 1);
    check("f1_ferr", framing_cnt, 0);
    check("f1_ovr", overrun_cnt, 0);

    // Short low glitch must be rejected as a false start
    SIn = 1'b0;
    step(100);
    SIn = 1'b1;
    step(600);
    check("glitch_accepted", accepted, 1);
    check("glitch_ferr", framing_cnt, 0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0);
    step(50);
    check("f55_accepted", accepted, 2);

    // Low stop bit
    send_frame(8'hA5, 1'b0, 1'b0);
    step(600);
    check("ferr_count", framing_cnt, 1);
    check("ferr_accepted", accepted, 2);
    check("ferr_valid_cycles", valid_cycles, 2);

    // Overrun while holding register is full
    DataOutReady = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    step(50);
    check("ovr_valid", {31'h0, DataOutValid}, 32'h1);
    check("ovr_data_held", {24'h0, DataOut}, 32'h11);
    check("ovr_count", overrun_cnt, 1);
    DataOutReady = 1'b1;
    step(1);
    DataOutReady = 1'b0;
    step(2);
    check("ovr_valid_drop", {31'h0, DataOutValid}, 32'h0);
    check("ovr_accepted", accepted, 3);
    DataOutReady = 1'b1;

    // Three frames with no idle gap
    vc_snap = valid_cycles;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h3C);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    step(50);
    check("b2b_accepted", accepted, 6);
    check("b2b_valid_cycles", valid_cycles - vc_snap, 3);
    check("b2b_queue_empty", exp_q.size(), 0);
    check("b2b_ovr", overrun_cnt, 1);

    // Reset in the middle of data bit 4
    SIn = 1'b0;
    step(Bit);
    for (int i = 0; i < 4; i++) begin
      SIn = 8'h7a >> i;
      step(Bit);
    end
    SIn = 1'b1;
    step(200);
    Reset = 1'b0;
    step(10);
    check("midrst_data", {24'h0, DataOut}, 32'h00);
    check("midrst_valid", {31'h0, DataOutValid}, 32'h0);
    SIn = 1'b1;
    Reset = 1'b1;
    step(1000);
    check("midrst_accepted", accepted, 6);
    check("midrst_ferr", framing_cnt, 1);
    exp_q.push_back(8'h7a);
    send_frame(8'h7a, 1'b1, 1'b0);
    step(50);
    check("post_rst_accepted", accepted, 7);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h7a, 1'b1, 1'b1);
    step(600);
    check("perr_count", parity_cnt, 1);
    check("perr_accepted", accepted, 7);
`else
    check("perr_none", parity_cnt, 0);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
